// File: rtl/candy_sram_wbuf_pkg.sv
// Shared constants for the SRAM write buffer.
// These values track the SRAM width and write-buffer macros kept in candy_defines.v.
package candy_sram_wbuf_pkg;

    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_ADDR_W = 16;
    localparam int WBUF_DEPTH  = 4;
    localparam int WBUF_PTR_W  = 3;

endpackage

// File: rtl/candy_wbuf_fwd_match.sv
// Store-to-load forwarding lookup for the write buffer.
// Walks the entries from head (oldest) toward tail. A later match overrides an earlier one,
// so the youngest matching store wins. Only instantiated when STORE_FWD_EN is defined.
module candy_wbuf_fwd_match
    import candy_sram_wbuf_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W,
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DEPTH  = WBUF_DEPTH
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
    input  logic [DEPTH-1:0]             ent_valid,
    input  logic [$clog2(DEPTH)-1:0]     head_idx,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data
);
    localparam int IDX_W = $clog2(DEPTH);

    // Oldest-to-youngest scan; the last hit seen is the youngest matching entry
    always_comb begin
        logic [IDX_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head_idx;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_idx + IDX_W'(i);
            if (ent_valid[idx] && (ent_addr[idx] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/candy_sram_wbuf.sv
// SRAM write buffer: queues WB-stage stores in a DEPTH-entry FIFO and drains them to the
// SRAM port under an ack handshake.
// Optional feature macro: STORE_FWD_EN adds a store-to-load forwarding lookup on rd_addr.
// All SRAM-side outputs come from registered state only, so there is no wr_* -> sram_* path.
module candy_sram_wbuf
    import candy_sram_wbuf_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W,
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DEPTH  = WBUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_enable,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    output logic                   sram_we,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    input  logic                   sram_ack,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [IDX_W-1:0]             wr_idx;
    logic [IDX_W-1:0]             rd_idx;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0]             ent_valid;
    logic                         empty;
    logic                         full;
    logic                         push;
    logic                         pop;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    // A same-cycle pop never frees a slot for a push: wr_ready looks at pointers only
    assign wr_ready = !full;
    assign push     = wr_enable && !full;
    assign pop      = !empty && sram_ack;

    // Head entry presented to SRAM; zeroed while empty so the bus is quiet
    assign sram_we    = !empty;
    assign sram_addr  = empty ? '0 : ent_addr[rd_idx];
    assign sram_wdata = empty ? '0 : ent_data[rd_idx];

    // Pointers, occupancy, entry valids and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
            ovf_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr            <= wr_ptr + PTR_W'(1);
                ent_valid[wr_idx] <= 1'b1;
            end
            if (pop) begin
                rd_ptr            <= rd_ptr + PTR_W'(1);
                ent_valid[rd_idx] <= 1'b0;
            end
            if (push && !pop) begin
                count <= count + PTR_W'(1);
            end else if (pop && !push) begin
                count <= count - PTR_W'(1);
            end
            if (wr_enable && full) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // Entry payload storage; contents are qualified by pointers/valids so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_idx] <= wr_addr;
            ent_data[wr_idx] <= wr_data;
        end
    end

`ifdef STORE_FWD_EN
    candy_wbuf_fwd_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fwd_match (
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_valid (ent_valid),
        .head_idx  (rd_idx),
        .rd_addr   (rd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );
`else
    // No lookup: forwarding outputs tied off, lookup address and valids are sunk
    logic unused_fwd;
    assign unused_fwd = ^{rd_addr, ent_valid};
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_candy_sram_wbuf.sv
// Self-checking bench for candy_sram_wbuf: vector table plus hand-written corner sequences,
// with a queue scoreboard of accepted stores compared against the SRAM port on every ack.
module tb_candy_sram_wbuf;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam int NV     = 21;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_enable = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_ack = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [2:0]        count;
    logic              ovf_err;

    always #5 clk = ~clk;

    candy_sram_wbuf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_ack(sram_ack), .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count), .ovf_err(ovf_err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              ack;
        int                exp_count;
        logic              exp_we;
        logic              exp_ready;
        logic              exp_ovf;
    } vec_t;

    ent_t sbq[$];
    logic mov = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Snapshot of DUT outputs taken mid-cycle by cycle()
    int   s_count;
    logic s_we, s_ready, s_ovf;

    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, check outputs mid-cycle against the scoreboard, then update the model
    task automatic cycle(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic ack);
        bit   push, pop, hit;
        logic [DATA_W-1:0] fd;
        ent_t e;
        wr_enable = we; wr_addr = a; wr_data = d; sram_ack = ack;
        @(negedge clk);
        s_count = int'(count); s_we = sram_we; s_ready = wr_ready; s_ovf = ovf_err;
        chk("count", 32'(count), 32'(sbq.size()));
        chk("wr_ready", 32'(wr_ready), 32'(sbq.size() < DEPTH));
        chk("sram_we", 32'(sram_we), 32'(sbq.size() != 0));
        chk("ovf_err", 32'(ovf_err), 32'(mov));
        if (sbq.size() != 0) begin
            chk("sram_addr", 32'(sram_addr), 32'(sbq[0].addr));
            chk("sram_wdata", sram_wdata, sbq[0].data);
        end else begin
            chk("sram_addr_idle", 32'(sram_addr), 32'h0);
            chk("sram_wdata_idle", sram_wdata, 32'h0);
        end
        hit = 1'b0; fd = '0;
`ifdef STORE_FWD_EN
        foreach (sbq[i]) if (sbq[i].addr == rd_addr) begin hit = 1'b1; fd = sbq[i].data; end
`endif
        chk("fwd_hit", 32'(fwd_hit), 32'(hit));
        chk("fwd_data", fwd_data, fd);
        push = we && (sbq.size() < DEPTH);
        pop  = ack && (sbq.size() != 0);
        if (we && sbq.size() == DEPTH) mov = 1'b1;
        if (pop) e = sbq.pop_front();
        if (push) begin e.addr = a; e.data = d; sbq.push_back(e); end
        @(posedge clk); #1;
    endtask

    // Two reset cycles with a push held on; outputs must come up idle
    task automatic do_reset();
        rst = 1'b0; wr_enable = 1'b1; wr_addr = 16'h0BAD; wr_data = 32'hBADBAD00; sram_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_sram_we", 32'(sram_we), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h1);
        chk("rst_ovf", 32'(ovf_err), 32'h0);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'h0);
        sbq.delete(); mov = 1'b0;
        rst = 1'b1; wr_enable = 1'b0; sram_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // Expected columns are the outputs seen during that cycle, before its closing edge
        //           we    addr      data          ack  cnt we    rdy   ovf
        vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 32'h0,        1'b0, 1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 32'h0,        1'b0, 1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 32'h0,        1'b0, 1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 32'h0,        1'b0, 1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 32'h0,        1'b0, 1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 32'h0,        1'b1, 1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 32'h0,        1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 16'h0100, 32'hA0A0A0A0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h0104, 32'hA1A1A1A1, 1'b0, 1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 16'h0108, 32'hA2A2A2A2, 1'b0, 2, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 16'h010C, 32'hA3A3A3A3, 1'b0, 3, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 16'h0110, 32'hA4A4A4A4, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 16'h0114, 32'hA5A5A5A5, 1'b1, 4, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 16'h0000, 32'h0,        1'b1, 3, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 16'h0000, 32'h0,        1'b1, 2, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 16'h0000, 32'h0,        1'b1, 1, 1'b1, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 16'h0000, 32'h0,        1'b0, 0, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 16'h0000, 32'h0,        1'b1, 0, 1'b0, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 16'h0000, 32'h0,        1'b0, 0, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b1, 16'h0200, 32'h12345678, 1'b1, 0, 1'b0, 1'b1, 1'b1};

        // Reset with pushes asserted
        do_reset();

        // Single store hold/ack, then fill-to-full, overflow, and in-order drain
        rd_addr = 16'h0010;
        for (int i = 0; i < NV; i++) begin
            cycle(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].ack);
            chk($sformatf("vec%0d_count", i), 32'(s_count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_we", i), 32'(s_we), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_ovf", i), 32'(s_ovf), 32'(vecs[i].exp_ovf));
        end
        cycle(1'b0, '0, '0, 1'b1);
        chk("post_table_count", 32'(count), 32'h0);

        // Steady push+ack with two entries resident; pointers wrap repeatedly
        do_reset();
        cycle(1'b1, 16'h0300, 32'h30000000, 1'b0);
        cycle(1'b1, 16'h0301, 32'h30000001, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 16'h0302 + 16'(i), $urandom, 1'b1);
            chk("steady_count", 32'(count), 32'h2);
        end
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        chk("steady_drained", 32'(count), 32'h0);

        // Forwarding: youngest of two same-address stores wins
        cycle(1'b1, 16'h0040, 32'h00000001, 1'b0);
        cycle(1'b1, 16'h0040, 32'h00000002, 1'b0);
        rd_addr = 16'h0040; #1;
`ifdef STORE_FWD_EN
        chk("fwd_young_hit", 32'(fwd_hit), 32'h1);
        chk("fwd_young_data", fwd_data, 32'h2);
`else
        chk("fwd_off_hit", 32'(fwd_hit), 32'h0);
        chk("fwd_off_data", fwd_data, 32'h0);
`endif
        rd_addr = 16'h0044; #1;
        chk("fwd_miss_hit", 32'(fwd_hit), 32'h0);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);

        // Reset mid-drain discards pending entries; next store is presented cleanly
        cycle(1'b1, 16'h0500, 32'h50000000, 1'b0);
        cycle(1'b1, 16'h0501, 32'h50000001, 1'b0);
        cycle(1'b1, 16'h0502, 32'h50000002, 1'b0);
        cycle(1'b1, 16'h0503, 32'h50000003, 1'b1);
        chk("pre_rst_count", 32'(count), 32'h3);
        do_reset();
        cycle(1'b1, 16'h0777, 32'h77777777, 1'b0);
        chk("post_rst_count", 32'(count), 32'h1);
        chk("post_rst_addr", 32'(sram_addr), 32'h0777);
        chk("post_rst_data", sram_wdata, 32'h77777777);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
